// File: rtl/scroll_layer.sv
// Horizontally scrolling background strip: a writable ROWS x PATTERN_W bitmap
// scrolled left by a per-frame speed that ramps up during play.
// Latency: pixel_on is registered, 1 cycle after h_cnt/v_cnt; no backpressure (free-running pixel path).
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   h_cnt, v_cnt        current pixel column / line from the VGA timing generator
//   state               game state: 0 idle, 1/2 running, 3 game over
//   new_frame           one-cycle pulse per frame; advances scroll position and speed ramp
//   wr_en/wr_row/wr_data  runtime pattern row write (bit i = pattern column i)
//   pixel_on            strip pixel lit (registered)
//   speed, pos          current scroll speed and scroll offset (registered)
//   wrap_tick           only with SCROLL_LAYER_WRAP_TICK_EN defined: one-cycle pulse
//                       after a running frame update in which pos wrapped
//
// Optional feature macro: SCROLL_LAYER_WRAP_TICK_EN (adds the wrap_tick output).

module scroll_layer #(
    parameter int PATTERN_W   = 160,
    parameter int ROWS        = 8,
    parameter int Y_TOP       = 400,
    parameter int SPEED_INIT  = 6,
    parameter int SPEED_MAX   = 15,
    parameter int RAMP_FRAMES = 600,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int POS_W = $clog2(PATTERN_W),
    localparam int SPD_W = $clog2(SPEED_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           h_cnt,
    input  logic [9:0]           v_cnt,
    input  logic [1:0]           state,
    input  logic                 new_frame,
    input  logic                 wr_en,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic [PATTERN_W-1:0] wr_data,
    output logic                 pixel_on,
    output logic [SPD_W-1:0]     speed,
    output logic [POS_W-1:0]     pos
`ifdef SCROLL_LAYER_WRAP_TICK_EN
    ,
    output logic                 wrap_tick
`endif
);

    localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_FRAMES - 1);
    localparam logic [SPD_W-1:0]  SPD_INIT_V = SPD_W'(SPEED_INIT);
    localparam logic [SPD_W-1:0]  SPD_MAX_V  = SPD_W'(SPEED_MAX);
    localparam logic [POS_W:0]    PW_EXT     = (POS_W + 1)'(PATTERN_W);
    localparam logic [31:0]       ROWS_U     = ROWS;
    localparam logic [31:0]       Y_LO       = Y_TOP;
    localparam logic [31:0]       Y_HI       = Y_TOP + ROWS;
    localparam logic [10:0]       PW_COL     = 11'(PATTERN_W);

    // ------------------------------------------------------------------
    // Pattern memory. Deliberately not touched by rst so a stage loaded
    // before a game reset survives; powers up as all zeros.
    // ------------------------------------------------------------------
    logic [PATTERN_W-1:0] pattern [ROWS] = '{default: '0};

    logic wr_ok;
    assign wr_ok = wr_en && ({{(32 - ROW_W){1'b0}}, wr_row} < ROWS_U);

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            pattern[wr_row] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Scroll position / speed state
    // ------------------------------------------------------------------
    logic              running;
    logic              frame_run;
    logic              frame_idle;
    logic [POS_W:0]    pos_sum;
    logic              pos_wrap;
    logic [POS_W-1:0]  pos_next;
    logic [SPD_W-1:0]  speed_inc;
    logic [RAMP_W-1:0] ramp_cnt;

    assign running    = (state == 2'd1) || (state == 2'd2);
    assign frame_run  = new_frame && running;
    assign frame_idle = new_frame && (state == 2'd0);

    // One extra bit of headroom so pos + speed never overflows before the
    // wrap compare; SPEED_MAX <= PATTERN_W keeps a single subtract sufficient.
    always_comb begin
        pos_sum  = {1'b0, pos} + (POS_W + 1)'(speed);
        pos_wrap = (pos_sum >= PW_EXT);
        pos_next = pos_wrap ? POS_W'(pos_sum - PW_EXT) : pos_sum[POS_W-1:0];
    end

    assign speed_inc = (speed >= SPD_MAX_V) ? SPD_MAX_V : speed + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            speed    <= SPD_INIT_V;
            ramp_cnt <= '0;
        end else if (frame_run) begin
            // pos advances with the speed in effect before any ramp step
            pos <= pos_next;
            if (ramp_cnt == RAMP_LAST) begin
                ramp_cnt <= '0;
                speed    <= speed_inc;
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end else if (frame_idle) begin
            speed    <= SPD_INIT_V;
            ramp_cnt <= '0;
        end
    end

`ifdef SCROLL_LAYER_WRAP_TICK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_tick <= 1'b0;
        end else begin
            wrap_tick <= frame_run && pos_wrap;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pixel lookup. Uses the current (pre-update) pos register, so a
    // lookup coinciding with new_frame sees the old offset.
    // ------------------------------------------------------------------
    logic             in_rows;
    logic             in_cols;
    logic [9:0]       v_diff;
    logic [ROW_W-1:0] rd_row;
    logic [10:0]      col_sum;
    logic [10:0]      col_mod;
    logic [POS_W-1:0] bit_idx;
    logic             pix_next;

    always_comb begin
        in_rows  = ({22'd0, v_cnt} >= Y_LO) && ({22'd0, v_cnt} < Y_HI);
        in_cols  = (h_cnt < 10'd640);
        v_diff   = v_cnt - Y_LO[9:0];
        rd_row   = v_diff[ROW_W-1:0];
        // Sum reaches 639 + PATTERN_W - 1, which can span more than one
        // pattern period, so a full modulo rather than a conditional subtract.
        col_sum  = {1'b0, h_cnt} + 11'(pos);
        col_mod  = col_sum % PW_COL;
        bit_idx  = col_mod[POS_W-1:0];
        pix_next = 1'b0;
        if (in_rows && in_cols) begin
            pix_next = pattern[rd_row][bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= pix_next;
        end
    end

endmodule

// File: tb/tb_scroll_layer.sv
module tb_scroll_layer;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   h_cnt;
    logic [9:0]   v_cnt;
    logic [1:0]   state;
    logic         new_frame;
    logic         wr_en;
    logic [2:0]   wr_row;
    logic [159:0] wr_data;
    logic         pixel_on;
    logic [3:0]   speed;
    logic [7:0]   pos;
`ifdef SCROLL_LAYER_WRAP_TICK_EN
    logic         wrap_tick;
`endif

    int total = 0;
    int bad   = 0;

    scroll_layer dut (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .state     (state),
        .new_frame (new_frame),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .pixel_on  (pixel_on),
        .speed     (speed),
        .pos       (pos)
`ifdef SCROLL_LAYER_WRAP_TICK_EN
        ,
        .wrap_tick (wrap_tick)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n one-cycle new_frame pulses; returns at the negedge after the last update edge
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) new_frame = 1'b1;
            @(negedge clk) new_frame = 1'b0;
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [159:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_row = r; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic exp);
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v);
        @(negedge clk);
        chk(tag, {31'd0, pixel_on}, {31'd0, exp});
    endtask

    initial begin
        logic [159:0] ones;
        logic [159:0] bit11;
        ones  = {160{1'b1}};
        bit11 = 160'd1 << 11;

        rst = 1'b1; h_cnt = '0; v_cnt = '0; state = 2'd0; new_frame = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_pos", 32'(pos), 0);
        chk("rst_speed", 32'(speed), 6);
        chk("rst_pix", {31'd0, pixel_on}, 0);
`ifdef SCROLL_LAYER_WRAP_TICK_EN
        chk("rst_wrap", {31'd0, wrap_tick}, 0);
`endif

        // Running with defaults: 6 px per frame
        state = 2'd1;
        frames(1); chk("f1_pos", 32'(pos), 6);
        frames(1); chk("f2_pos", 32'(pos), 12);
        frames(1); chk("f3_pos", 32'(pos), 18);
        chk("f3_speed", 32'(speed), 6);
        chk("f3_pix", {31'd0, pixel_on}, 0);

        // 23 more frames -> 156, then wrap to 2 in state 2
        frames(23); chk("pos156", 32'(pos), 156);
        state = 2'd2;
        frames(1); chk("wrap_pos", 32'(pos), 2);
`ifdef SCROLL_LAYER_WRAP_TICK_EN
        chk("wrap_tick_hi", {31'd0, wrap_tick}, 1);
        @(negedge clk);
        chk("wrap_tick_lo", {31'd0, wrap_tick}, 0);
`endif
        state = 2'd1;

        // Ramp: 27 frames so far; frame 599 still speed 6, frame 600 -> 7
        frames(572);
        chk("f599_speed", 32'(speed), 6);
        chk("f599_pos", 32'(pos), 74);
        frames(1);
        chk("f600_speed", 32'(speed), 7);
        chk("f600_pos", 32'(pos), 80);

        // Eight more increments reach saturation, then 600 more frames hold it
        frames(4800);
        chk("f5400_speed", 32'(speed), 15);
        chk("f5400_pos", 32'(pos), 80);
        frames(600);
        chk("sat_speed", 32'(speed), 15);
        chk("sat_pos", 32'(pos), 120);
        frames(3);
        chk("pos5", 32'(pos), 5);

        // Pattern lookups at pos=5
        wr(3'd0, ones);
        wr(3'd2, bit11);
        pix("v400_h0", 0, 400, 1'b1);
        pix("v402_h6", 6, 402, 1'b1);
        pix("v402_h7", 7, 402, 1'b0);
        pix("v402_h486", 486, 402, 1'b1);
        pix("v402_h155", 155, 402, 1'b0);
        pix("v399", 0, 399, 1'b0);
        pix("v408", 0, 408, 1'b0);
        pix("h650", 650, 400, 1'b0);

        // Write row 3 while reading it: old data, then new data
        @(negedge clk);
        wr_en = 1'b1; wr_row = 3'd3; wr_data = ones;
        h_cnt = 10'd0; v_cnt = 10'd403;
        @(negedge clk);
        wr_en = 1'b0;
        chk("rw_old", {31'd0, pixel_on}, 0);
        @(negedge clk);
        chk("rw_new", {31'd0, pixel_on}, 1);

        // Lookup in the same cycle as a frame update uses the old pos
        @(negedge clk);
        h_cnt = 10'd6; v_cnt = 10'd402; new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        chk("pre_pos_pix", {31'd0, pixel_on}, 1);
        chk("pre_pos_pos", 32'(pos), 20);

        // Game over freezes everything
        state = 2'd3;
        frames(3);
        chk("over_pos", 32'(pos), 20);
        chk("over_speed", 32'(speed), 15);

        // Idle frame restores speed, clears ramp, keeps pos
        state = 2'd0;
        frames(1);
        chk("idle_speed", 32'(speed), 6);
        chk("idle_pos", 32'(pos), 20);
        state = 2'd1;
        frames(599);
        chk("ramp_clr_speed", 32'(speed), 6);
        chk("ramp_clr_pos", 32'(pos), 94);
        frames(1);
        chk("ramp_next_speed", 32'(speed), 7);
        chk("ramp_next_pos", 32'(pos), 100);

        // Reset mid-frame while reading a lit pixel
        @(negedge clk);
        h_cnt = 10'd0; v_cnt = 10'd400; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_pos", 32'(pos), 0);
        chk("mid_rst_pix", {31'd0, pixel_on}, 0);
        chk("mid_rst_speed", 32'(speed), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
